reg_scoreboard: RTL
===================

# reg_scoreboard

Register-file scoreboard that schedules decode-stage issue around long-latency writebacks (multi-cycle loads over the memory bus, iterative divide). It sits beside the decode stage. It records which architectural registers have a write outstanding from an already-issued long-latency op, and raises a stall request to the pipeline controller on RAW or WAW conflicts or when the outstanding-op budget is exhausted. Its stall request is OR-ed with the single-cycle load-use stall; it does not replace it.

## Interface
- MAX_OUT, default 4: maximum simultaneously outstanding long-latency writes, range 1..31.
- I_clk  input  1  clock, rising edge.
- I_rst  input  1  asynchronous, active-high reset.
- I_dec_rs1_re  input  1  decode reads rs1.
- I_dec_rs1_raddr  input  `RegAddrBus  rs1 index.
- I_dec_rs2_re  input  1  decode reads rs2.
- I_dec_rs2_raddr  input  `RegAddrBus  rs2 index.
- I_dec_rd_we  input  1  decode writes rd.
- I_dec_rd_waddr  input  `RegAddrBus  rd index.
- I_dec_long  input  1  decode instruction is long-latency (load or div).
- I_issue_valid  input  1  decode instruction advances to EX this cycle; the controller asserts it only when not stalled.
- I_flush  input  1  the instruction issuing this cycle is killed (branch taken or trap).
- I_wb_valid  input  1  long-latency result written back this cycle.
- I_wb_waddr  input  `RegAddrBus  writeback register index.
- O_stallreq  output  1  hold decode.
- O_busy  output  1  at least one write is outstanding.
- O_pending_cnt  output  5  number of outstanding writes.
- O_err  output  1  sticky: writeback to a register that was not pending.

## Operation
- State: pending[31:1], one bit per register. Register x0 is never pending, and its reads and writes never hazard. Also held: cnt (5 bits) and err.
- set = I_issue_valid & I_dec_rd_we & I_dec_long & (I_dec_rd_waddr != 0) & ~I_flush. It sets pending[rd].
- clr = I_wb_valid & (I_wb_waddr != 0) & pending[I_wb_waddr]. It clears that bit.
- set and clr on the same register in the same cycle: set wins, so the bit stays 1. cnt is unchanged.
- cnt update:
  - +1 on set only.
  - −1 on clr only.
  - unchanged when both or neither.
- cnt always equals popcount(pending). The bench checks this as an invariant.
- I_wb_valid to a non-pending register, or to x0 when it is not pending: no state change, and err is set to 1 and held until reset.
- Hazards are evaluated against eff_pending, which is pending with the same-cycle writeback bit removed (see Configuration):
  - raw = (rs1_re & eff_pending[rs1]) | (rs2_re & eff_pending[rs2]).
  - waw = rd_we & eff_pending[rd].
  - full = I_dec_long & rd_we & (rd != 0) & (eff_cnt == MAX_OUT).
- O_stallreq = raw | waw | full. It is purely combinational from state and the current decode and writeback inputs.
- I_flush does not clear existing pending bits. Ops already issued are older than the flushing branch and always complete.

## Timing
- Reset values:
  - pending = 0, cnt = 0, err = 0.
  - O_busy = 0, O_pending_cnt = 0, O_err = 0.
  - O_stallreq = 0, because all hazard terms are 0 when state is 0.
- A set at edge N makes O_stallreq visible for a dependent decode from cycle N+1 onward.
- A clear at edge N releases a dependent decode in cycle N+1 without bypass, or in cycle N with bypass.
- Reset mid-operation: all bits clear immediately. Writebacks that arrive after reset are non-pending and raise O_err. The LSU and divider must therefore be reset together with this block.
- O_busy = (cnt != 0), registered-derived.

## Configuration
- SCB_WB_BYPASS_EN defined:
  - eff_pending = pending & ~onehot(clr).
  - eff_cnt = cnt − clr.
  - The register file forwards the WB value to decode, so a dependent decode issues in the same cycle as the writeback.
- Undefined:
  - eff_pending = pending and eff_cnt = cnt.
  - Minimum stall after a writeback is 1 extra cycle.

## Structure
- MAX_OUT bounds and a `ScbCntBus` (4:0) define go in defines.v alongside `RegAddrBus`.
- One sub-module, scb_dec5to32: 5-to-32 one-hot decoder. It is instantiated twice, for set and for clr.

## Test plan
- Load to x5 issues. 3 cycles later a decode reads x5 via rs2 -> O_stallreq stays 1 until the wb x5 cycle (bypass) or the cycle after (no bypass), and O_pending_cnt goes 1 to 0.
- Issue a long op to x5 with I_flush=1 -> pending unchanged, cnt 0, no stall on a following read of x5.
- MAX_OUT=4: issue loads to x1..x4, then decode a load to x6 -> stall. Wb x2 -> stall releases, and after the x6 issue cnt is 4.
- Decode a long op with rd=x7 while x7 is pending -> WAW stall. Same-cycle wb x7 and issue x7 (bypass) -> pending[7]=1, cnt unchanged.
- Wb x9 while x9 is not pending -> O_err=1 and sticky, cnt unchanged. Decode reading or writing x0 never stalls.
- Assert I_rst with 3 outstanding -> all outputs 0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard shared types and helpers.
// Register index, pending mask and outstanding-count types.
package reg_scoreboard_pkg;

  localparam int REG_AW  = 5;
  localparam int NREG    = 32;
  localparam int CNT_W   = 5;
  localparam int MAX_OUT_LO = 1;
  localparam int MAX_OUT_HI = 31;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [CNT_W-1:0]  scb_cnt_t;
  typedef logic [NREG-1:0]   reg_mask_t;

  // One-step count update: a set and a clear in the same cycle cancel.
  function automatic scb_cnt_t cnt_step(
    input scb_cnt_t c,
    input logic     inc,
    input logic     dec
  );
    scb_cnt_t r;
    unique case ({inc, dec})
      2'b10:   r = c + scb_cnt_t'(1);
      2'b01:   r = c - scb_cnt_t'(1);
      default: r = c;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/reg_scoreboard_dec5to32.sv
// scb_dec5to32: 5-to-32 one-hot decoder with enable.
// Output is all-zero when the enable is low.
module scb_dec5to32
  import reg_scoreboard_pkg::*;
(
  input  logic      I_en,
  input  reg_addr_t I_addr,
  output reg_mask_t O_onehot
);

  // Drive a single bit selected by the address when enabled.
  always_comb begin
    O_onehot = '0;
    if (I_en) begin
      O_onehot[I_addr] = 1'b1;
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: tracks registers with long-latency writes in flight.
// Define SCB_WB_BYPASS_EN to let a same-cycle writeback release decode.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int MAX_OUT = 4
) (
  input  logic      I_clk,
  input  logic      I_rst,
  input  logic      I_dec_rs1_re,
  input  reg_addr_t I_dec_rs1_raddr,
  input  logic      I_dec_rs2_re,
  input  reg_addr_t I_dec_rs2_raddr,
  input  logic      I_dec_rd_we,
  input  reg_addr_t I_dec_rd_waddr,
  input  logic      I_dec_long,
  input  logic      I_issue_valid,
  input  logic      I_flush,
  input  logic      I_wb_valid,
  input  reg_addr_t I_wb_waddr,
  output logic      O_stallreq,
  output logic      O_busy,
  output scb_cnt_t  O_pending_cnt,
  output logic      O_err
);

  reg_mask_t pending_q;
  reg_mask_t pending_d;
  scb_cnt_t  cnt_q;
  scb_cnt_t  cnt_d;
  logic      err_q;
  logic      err_d;

  logic      set;
  logic      clr;
  reg_mask_t set_oh;
  reg_mask_t clr_oh;
  reg_mask_t eff_pending;
  scb_cnt_t  eff_cnt;

  logic      rd_nz;
  logic      raw;
  logic      waw;
  logic      full;

  assign rd_nz = (I_dec_rd_waddr != '0);

  // A surviving long op with a real destination marks rd pending.
  assign set = I_issue_valid & I_dec_rd_we & I_dec_long
             & rd_nz & ~I_flush;

  // Only a writeback that matches a pending register retires it.
  assign clr = I_wb_valid & (I_wb_waddr != '0)
             & pending_q[I_wb_waddr];

  scb_dec5to32 u_dec_set (
    .I_en     (set),
    .I_addr   (I_dec_rd_waddr),
    .O_onehot (set_oh)
  );

  scb_dec5to32 u_dec_clr (
    .I_en     (clr),
    .I_addr   (I_wb_waddr),
    .O_onehot (clr_oh)
  );

  // Next state: clear first so a same-register set wins; x0 stays clear.
  always_comb begin
    pending_d    = (pending_q & ~clr_oh) | set_oh;
    pending_d[0] = 1'b0;
    cnt_d        = cnt_step(cnt_q, set, clr);
    err_d        = err_q | (I_wb_valid & ~clr);
  end

  // State registers; reset drops every outstanding write at once.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      pending_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  // Hazard view of the pending set, optionally minus this cycle's writeback.
  always_comb begin
`ifdef SCB_WB_BYPASS_EN
    eff_pending = pending_q & ~clr_oh;
    eff_cnt     = cnt_q - {{(CNT_W-1){1'b0}}, clr};
`else
    eff_pending = pending_q;
    eff_cnt     = cnt_q;
`endif
  end

  // Stall on RAW, WAW, or when no outstanding slot is left for a long op.
  always_comb begin
    raw = (I_dec_rs1_re & eff_pending[I_dec_rs1_raddr])
        | (I_dec_rs2_re & eff_pending[I_dec_rs2_raddr]);
    waw = I_dec_rd_we & eff_pending[I_dec_rd_waddr];
    full = I_dec_long & I_dec_rd_we & rd_nz
         & (eff_cnt == scb_cnt_t'(MAX_OUT));
    O_stallreq = raw | waw | full;
  end

  assign O_busy        = (cnt_q != '0);
  assign O_pending_cnt = cnt_q;
  assign O_err         = err_q;

endmodule
